cache_refill_engine: RTL

Miss-handling engine between one cache way and the memory port. On a miss it writes back the dirty victim line as four 32-bit words. It then fetches the new line as four words and commits the assembled 128-bit line, with its tag, into the way in a single write cycle. It writes the way through the way's own write port (wr_en, addr, wr_data, wr_tag, wr_word_en) and talks word-serially to memory.

---
 rtl/cache_refill_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cache_refill_engine.sv
// Miss engine: writes back a dirty victim as four words, fills the new line word by word, then commits it to the way in one cycle.
// Latency: clean miss commits 5 cycles after accept, dirty miss 9; each mem_ack wait cycle adds one. Requests arriving while busy are dropped.
module cache_refill_engine #(
   parameter  int ADDR_WIDTH     = 5,
   parameter  int TAG_BITS       = 23,
   localparam int MEM_ADDR_WIDTH = TAG_BITS + ADDR_WIDTH + 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [TAG_BITS-1:0]       req_tag,
   input  logic [ADDR_WIDTH-1:0]     req_index,
   input  logic                      victim_dirty,
   input  logic [TAG_BITS-1:0]       victim_tag,
   input  logic [127:0]              victim_data,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]               mem_wdata,
   input  logic                      mem_ack,
   input  logic [31:0]               mem_rdata,
   output logic                      way_wr_en,
   output logic [ADDR_WIDTH-1:0]     way_addr,
   output logic [127:0]              way_wr_data,
   output logic [TAG_BITS-1:0]       way_wr_tag,
   output logic [3:0]                way_wr_word_en,
   output logic                      done
);

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_COMMIT} state_t;

   state_t                    state_q;
   logic [1:0]                cnt_q;
   logic [1:0]                cnt_inc;
   logic [TAG_BITS-1:0]       tag_q;
   logic [TAG_BITS-1:0]       vtag_q;
   logic [ADDR_WIDTH-1:0]     idx_q;
   logic [3:0][31:0]          vdata_q;
   logic [3:0][31:0]          line_q;
   logic                      mem_req_q;
   logic                      mem_we_q;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
   logic [31:0]               mem_wdata_q;
   logic                      wr_en_q;
   logic [3:0]                word_en_q;

   assign cnt_inc = cnt_q + 2'd1;

   // Memory-side outputs are loaded with the next word's values on the ack edge,
   // so nothing on the memory port depends combinationally on mem_ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         tag_q       <= '0;
         vtag_q      <= '0;
         idx_q       <= '0;
         vdata_q     <= '0;
         line_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wr_en_q     <= 1'b0;
         word_en_q   <= 4'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  tag_q     <= req_tag;
                  vtag_q    <= victim_tag;
                  idx_q     <= req_index;
                  vdata_q   <= victim_data;
                  cnt_q     <= 2'd0;
                  mem_req_q <= 1'b1;
                  if (victim_dirty) begin
                     state_q     <= S_WB;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= {victim_tag, req_index, 4'b0000};
                     mem_wdata_q <= victim_data[31:0];
                  end else begin
                     state_q     <= S_FILL;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= {req_tag, req_index, 4'b0000};
                     mem_wdata_q <= '0;
                  end
               end
            end
            S_WB: begin
               if (mem_ack) begin
                  cnt_q <= cnt_inc;
                  if (cnt_q == 2'd3) begin
                     state_q     <= S_FILL;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= {tag_q, idx_q, 4'b0000};
                     mem_wdata_q <= '0;
                  end else begin
                     mem_addr_q  <= {vtag_q, idx_q, cnt_inc, 2'b00};
                     mem_wdata_q <= vdata_q[cnt_inc];
                  end
               end
            end
            S_FILL: begin
               if (mem_ack) begin
                  line_q[cnt_q] <= mem_rdata;
                  cnt_q         <= cnt_inc;
                  if (cnt_q == 2'd3) begin
                     state_q    <= S_COMMIT;
                     mem_req_q  <= 1'b0;
                     mem_addr_q <= '0;
                     wr_en_q    <= 1'b1;
                     word_en_q  <= 4'hF;
                  end else begin
                     mem_addr_q <= {tag_q, idx_q, cnt_inc, 2'b00};
                  end
               end
            end
            S_COMMIT: begin
               state_q   <= S_IDLE;
               wr_en_q   <= 1'b0;
               word_en_q <= 4'h0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready      = (state_q == S_IDLE) && !rst;
   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign way_wr_en      = wr_en_q;
   assign done           = wr_en_q;
   assign way_wr_word_en = word_en_q;
   assign way_addr       = idx_q;
   assign way_wr_tag     = tag_q;
   assign way_wr_data    = line_q;

endmodule
